// File: rtl/seq_hit_logger.sv
// Timestamps rising edges of the detector output into a DEPTH-entry FIFO; an entry is readable 1 cycle after its hit.
// Reader pops via rd_valid/rd_ready; a hit arriving while full without a same-cycle pop is dropped and ovf is set (sticky).
module seq_hit_logger #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     det_in,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_data,
  output logic [CNT_W-1:0]         hit_count,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [TS_W-1:0] mem [DEPTH];
  logic [TS_W-1:0] ts;
  logic            det_q;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            hit;
  logic            pop;
  logic            full;
  logic            push;
  logic            drop;

  assign hit      = det_in & ~det_q & en;
  assign rd_valid = (fill != '0);
  assign rd_data  = mem[rd_ptr];
  assign pop      = rd_valid & rd_ready;
  assign full     = (fill == FULL_LVL);
  // A same-cycle pop frees the slot, so a hit on a full FIFO is only lost without one.
  assign push     = hit & (~full | pop);
  assign drop     = hit & full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts        <= '0;
      det_q     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      hit_count <= '0;
      ovf       <= 1'b0;
    end else begin
      det_q <= det_in;
      if (en) ts <= ts + 1'b1;
      // clear flushes buffer state only; ts and det_q keep running.
      if (clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        fill      <= '0;
        hit_count <= '0;
        ovf       <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      fill <= fill + 1'b1;
        else if (pop && !push) fill <= fill - 1'b1;
        if (drop) ovf <= 1'b1;
        if (hit && (hit_count != '1)) hit_count <= hit_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= ts;
  end

endmodule

// File: tb/tb_seq_hit_logger.sv
// Bench for seq_hit_logger: vector table, directed corner sequences, and random traffic vs. a queue model.
module tb_seq_hit_logger;
  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             clear = 1'b0;
  logic             det_in = 1'b0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [TS_W-1:0]  rd_data;
  logic [CNT_W-1:0] hit_count;
  logic             ovf;
  logic [2:0]       fill;

  seq_hit_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .det_in(det_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .hit_count(hit_count), .ovf(ovf), .fill(fill)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: timestamp, previous det level, queue of buffered stamps.
  int  m_ts = 0;
  int  m_hc = 0;
  bit  m_prev = 1'b0;
  bit  m_ovf = 1'b0;
  int  q[$];

  typedef struct {
    bit e; bit c; bit d; bit r;
    bit v; int data; int fl; int hc; bit ov;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, " fill"}, int'(fill), q.size());
    chk({tag, " rd_valid"}, int'(rd_valid), int'(q.size() != 0));
    if (q.size() != 0) chk({tag, " rd_data"}, int'(rd_data), q[0]);
    chk({tag, " hit_count"}, int'(hit_count), m_hc);
    chk({tag, " ovf"}, int'(ovf), int'(m_ovf));
  endtask

  task automatic step(bit e, bit d, bit r, bit c);
    bit hit;
    bit pop;
    en = e; det_in = d; rd_ready = r; clear = c;
    hit = d && !m_prev && e;
    pop = r && (q.size() != 0);
    if (c) begin
      q.delete();
      m_hc = 0;
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (hit) begin
        if (q.size() < DEPTH) q.push_back(m_ts);
        else m_ovf = 1'b1;
        if (m_hc < (1 << CNT_W) - 1) m_hc++;
      end
    end
    m_prev = d;
    if (e) m_ts = (m_ts + 1) % (1 << TS_W);
    @(posedge clk); #1;
    chk_model("mdl");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst rd_valid", int'(rd_valid), 0);
    chk("rst fill", int'(fill), 0);
    chk("rst hit_count", int'(hit_count), 0);
    chk("rst ovf", int'(ovf), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    m_ts = 0; m_hc = 0; m_ovf = 1'b0; m_prev = 1'b0;
  endtask

  task automatic idle_to(int target, bit r);
    int n = 0;
    while (m_ts != target && n < 600) begin
      step(1'b1, 1'b0, r, 1'b0);
      n++;
    end
    if (m_ts != target) begin
      checks++;
      failures++;
      $display("FAIL idle_to: ts %0d never reached %0d", m_ts, target);
    end
  endtask

  task automatic hit_at(int t);
    idle_to(t, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(string name, int exp);
    chk(name, int'(rd_data), exp);
    step(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    //               e  c  d  r   v  data fl hc ov
    tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0,  1, 1, 1, 1, 0};
    tbl[2]  = '{1, 0, 1, 0,  1, 1, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, 0,  1, 1, 1, 1, 0};
    tbl[4]  = '{1, 0, 1, 1,  1, 4, 1, 2, 0};
    tbl[5]  = '{0, 0, 0, 1,  0, 0, 0, 2, 0};
    tbl[6]  = '{0, 0, 1, 0,  0, 0, 0, 2, 0};
    tbl[7]  = '{1, 0, 1, 0,  0, 0, 0, 2, 0};
    tbl[8]  = '{1, 0, 0, 0,  0, 0, 0, 2, 0};
    tbl[9]  = '{1, 0, 1, 0,  1, 7, 1, 3, 0};
    tbl[10] = '{1, 1, 0, 0,  0, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 1, 1,  1, 9, 1, 1, 0};

    #1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].e, tbl[i].d, tbl[i].r, tbl[i].c);
      chk($sformatf("vec%0d rd_valid", i), int'(rd_valid), int'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("vec%0d rd_data", i), int'(rd_data), tbl[i].data);
      chk($sformatf("vec%0d fill", i), int'(fill), tbl[i].fl);
      chk($sformatf("vec%0d hit_count", i), int'(hit_count), tbl[i].hc);
      chk($sformatf("vec%0d ovf", i), int'(ovf), int'(tbl[i].ov));
    end

    // single pulse at ts=5
    do_reset();
    hit_at(5);
    chk("pulse rd_valid", int'(rd_valid), 1);
    chk("pulse rd_data", int'(rd_data), 5);
    chk("pulse fill", int'(fill), 1);
    chk("pulse hit_count", int'(hit_count), 1);

    // held high four cycles from ts=10
    do_reset();
    idle_to(10, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("held fill", int'(fill), 1);
    chk("held rd_data", int'(rd_data), 10);
    chk("held hit_count", int'(hit_count), 1);

    // overflow: five hits into four slots
    do_reset();
    hit_at(2); hit_at(6); hit_at(10); hit_at(14); hit_at(18);
    chk("ovf fill", int'(fill), 4);
    chk("ovf flag", int'(ovf), 1);
    chk("ovf hit_count", int'(hit_count), 5);
    pop_expect("ovf pop0", 2);
    pop_expect("ovf pop1", 6);
    pop_expect("ovf pop2", 10);
    pop_expect("ovf pop3", 14);
    chk("ovf drained rd_valid", int'(rd_valid), 0);
    chk("ovf sticky", int'(ovf), 1);

    // full FIFO, hit and pop together
    do_reset();
    hit_at(2); hit_at(4); hit_at(6); hit_at(8);
    idle_to(10, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("fullpp fill", int'(fill), 4);
    chk("fullpp ovf", int'(ovf), 0);
    pop_expect("fullpp pop0", 4);
    pop_expect("fullpp pop1", 6);
    pop_expect("fullpp pop2", 8);
    pop_expect("fullpp pop3", 10);
    chk("fullpp drained", int'(rd_valid), 0);

    // timestamp wrap
    do_reset();
    hit_at(255);
    idle_to(2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrap fill", int'(fill), 2);
    pop_expect("wrap pop0", 255);
    pop_expect("wrap pop1", 2);

    // clear overriding hit and pop
    do_reset();
    hit_at(2); hit_at(4);
    chk("clr pre fill", int'(fill), 2);
    idle_to(6, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr fill", int'(fill), 0);
    chk("clr rd_valid", int'(rd_valid), 0);
    chk("clr hit_count", int'(hit_count), 0);
    chk("clr ovf", int'(ovf), 0);

    // reset mid-stream with det_in high across release
    hit_at(8); hit_at(10);
    det_in = 1'b1;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("post-rst rd_data", int'(rd_data), 0);
    chk("post-rst fill", int'(fill), 1);
    chk("post-rst hit_count", int'(hit_count), 1);

    // hit counter saturation
    do_reset();
    repeat (300) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
    end
    chk("sat hit_count", int'(hit_count), 255);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
